// File: rtl/cdc_handshake_4ph_pkg.sv
// Shared types and constants for the four-phase req/ack CDC channel.
// Build option: CDC_HS_3FF_EN selects three-flop synchronizers instead of two.
package cdc_pkg;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_REQ  = 2'd1,
    A_DROP = 2'd2
  } src_state_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_HOLD = 2'd1,
    B_ACK  = 2'd2
  } dst_state_t;

`ifdef CDC_HS_3FF_EN
  localparam int unsigned CDC_SYNC_STAGES = 3;
`else
  localparam int unsigned CDC_SYNC_STAGES = 2;
`endif

endpackage : cdc_pkg

// File: rtl/cdc_handshake_4ph_sync_bit.sv
// Single-bit multi-flop synchronizer; all stages reset to 0.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the incoming bit one stage deeper per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchronizer flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/cdc_handshake_4ph.sv
// Four-phase req/ack CDC channel moving one held word from clkA to clkB.
// Only req and ack cross domains; the data register is stable while req=1.
// Build option: CDC_HS_3FF_EN (three-flop synchronizers on req and ack).
module cdc_handshake_4ph
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clkA_i,
  input  logic                  cA_rst_ni,
  input  logic                  cA_valid_i,
  input  logic [DATA_WIDTH-1:0] cA_din_i,
  output logic                  cA_rdy_o,
  input  logic                  clkB_i,
  input  logic                  cB_rst_ni,
  output logic                  cB_valid_o,
  output logic [DATA_WIDTH-1:0] cB_dout_o,
  input  logic                  cB_rdy_i
);

  // Source domain state
  src_state_t            a_state_q, a_state_d;
  logic                  req_q, req_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_sync;

  // Destination domain state
  dst_state_t            b_state_q, b_state_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  req_sync;

  cdc_sync_bit #(
    .STAGES(CDC_SYNC_STAGES)
  ) u_req_sync (
    .clk_i (clkB_i),
    .rst_ni(cB_rst_ni),
    .d_i   (req_q),
    .q_o   (req_sync)
  );

  cdc_sync_bit #(
    .STAGES(CDC_SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clkA_i),
    .rst_ni(cA_rst_ni),
    .d_i   (ack_q),
    .q_o   (ack_sync)
  );

  // Source FSM next state: accept a word, raise req, wait for ack rise then fall.
  always_comb begin
    a_state_d = a_state_q;
    req_d     = req_q;
    rdy_d     = rdy_q;
    data_d    = data_q;
    unique case (a_state_q)
      A_IDLE: begin
        if (cA_valid_i && rdy_q) begin
          data_d    = cA_din_i;
          req_d     = 1'b1;
          rdy_d     = 1'b0;
          a_state_d = A_REQ;
        end
      end
      A_REQ: begin
        if (ack_sync) begin
          req_d     = 1'b0;
          a_state_d = A_DROP;
        end
      end
      A_DROP: begin
        if (!ack_sync) begin
          rdy_d     = 1'b1;
          a_state_d = A_IDLE;
        end
      end
      default: begin
        req_d     = 1'b0;
        rdy_d     = 1'b1;
        a_state_d = A_IDLE;
      end
    endcase
  end

  // Source FSM registers.
  always_ff @(posedge clkA_i or negedge cA_rst_ni) begin
    if (!cA_rst_ni) begin
      a_state_q <= A_IDLE;
      req_q     <= 1'b0;
      rdy_q     <= 1'b1;
      data_q    <= '0;
    end else begin
      a_state_q <= a_state_d;
      req_q     <= req_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
    end
  end

  // Destination FSM next state: capture on req, hand over, ack until req falls.
  always_comb begin
    b_state_d = b_state_q;
    ack_d     = ack_q;
    valid_d   = valid_q;
    dout_d    = dout_q;
    unique case (b_state_q)
      B_IDLE: begin
        if (req_sync) begin
          dout_d    = data_q;
          valid_d   = 1'b1;
          b_state_d = B_HOLD;
        end
      end
      B_HOLD: begin
        if (valid_q && cB_rdy_i) begin
          valid_d   = 1'b0;
          ack_d     = 1'b1;
          b_state_d = B_ACK;
        end
      end
      B_ACK: begin
        if (!req_sync) begin
          ack_d     = 1'b0;
          b_state_d = B_IDLE;
        end
      end
      default: begin
        ack_d     = 1'b0;
        valid_d   = 1'b0;
        b_state_d = B_IDLE;
      end
    endcase
  end

  // Destination FSM registers.
  always_ff @(posedge clkB_i or negedge cB_rst_ni) begin
    if (!cB_rst_ni) begin
      b_state_q <= B_IDLE;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      b_state_q <= b_state_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
    end
  end

  assign cA_rdy_o   = rdy_q;
  assign cB_valid_o = valid_q;
  assign cB_dout_o  = dout_q;

endmodule : cdc_handshake_4ph

// File: tb/tb_cdc_handshake_4ph.sv
// Self-checking bench for cdc_handshake_4ph with a scoreboard of sent words.
module tb_cdc_handshake_4ph;

`ifdef CDC_HS_3FF_EN
  localparam int unsigned S = 3;
`else
  localparam int unsigned S = 2;
`endif

  logic       clkA_i, clkB_i;
  logic       cA_rst_ni, cB_rst_ni;
  logic       cA_valid_i;
  logic [7:0] cA_din_i;
  logic       cA_rdy_o;
  logic       cB_valid_o;
  logic [7:0] cB_dout_o;
  logic       cB_rdy_i;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned consumed = 0;
  int unsigned b_mode = 0;      // 0: rdy=1, 1: rdy=0, 2: random
  int unsigned ha = 50;         // clkA half period
  int unsigned hb = 135;        // clkB half period
  logic [7:0]  exp_q[$];

  cdc_handshake_4ph #(
    .DATA_WIDTH(8)
  ) dut (
    .clkA_i    (clkA_i),
    .cA_rst_ni (cA_rst_ni),
    .cA_valid_i(cA_valid_i),
    .cA_din_i  (cA_din_i),
    .cA_rdy_o  (cA_rdy_o),
    .clkB_i    (clkB_i),
    .cB_rst_ni (cB_rst_ni),
    .cB_valid_o(cB_valid_o),
    .cB_dout_o (cB_dout_o),
    .cB_rdy_i  (cB_rdy_i)
  );

  initial begin
    clkA_i = 1'b0;
    forever #(ha) clkA_i = ~clkA_i;
  end

  initial begin
    clkB_i = 1'b0;
    #13;
    forever #(hb) clkB_i = ~clkB_i;
  end

  // Destination driver and scoreboard: rdy is set on the falling edge and
  // held through the next rising edge, so valid&rdy here means a consume.
  initial begin
    cB_rdy_i = 1'b1;
    forever begin
      @(negedge clkB_i);
      case (b_mode)
        0: cB_rdy_i = 1'b1;
        1: cB_rdy_i = 1'b0;
        default: cB_rdy_i = 1'($urandom_range(0, 1));
      endcase
      if (cB_valid_o && cB_rdy_i) begin
        logic [7:0] e;
        consumed++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %h expected none", cB_dout_o);
        end else begin
          e = exp_q.pop_front();
          if (cB_dout_o !== e) begin
            errors++;
            $display("FAIL data got %h expected %h", cB_dout_o, e);
          end
        end
      end
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic send_word(input logic [7:0] d, input int unsigned gap);
    int unsigned w;
    repeat (gap + 1) @(negedge clkA_i);
    cA_valid_i = 1'b1;
    cA_din_i   = d;
    w = 0;
    while (!cA_rdy_o && w < 5000) begin
      @(negedge clkA_i);
      w++;
    end
    checks++;
    if (!cA_rdy_o) begin
      errors++;
      $display("FAIL send_timeout got rdy %b expected 1", cA_rdy_o);
    end else begin
      exp_q.push_back(d);
    end
    @(negedge clkA_i);
    cA_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clkB_i);
      w++;
    end
    repeat (4) @(negedge clkB_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_rdy(input string name);
    int unsigned w = 0;
    while (!cA_rdy_o && w < 5000) begin
      @(negedge clkA_i);
      w++;
    end
    checks++;
    if (cA_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy_return got %b expected 1", name, cA_rdy_o);
    end
  endtask

  task automatic test_reset();
    cA_rst_ni  = 1'b0;
    cB_rst_ni  = 1'b0;
    cA_valid_i = 1'b0;
    cA_din_i   = '0;
    repeat (4) @(negedge clkB_i);
    checks += 3;
    if (cA_rdy_o !== 1'b1) begin
      errors++; $display("FAIL reset_rdy got %b expected 1", cA_rdy_o);
    end
    if (cB_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b expected 0", cB_valid_o);
    end
    if (cB_dout_o !== 8'h00) begin
      errors++; $display("FAIL reset_dout got %h expected 00", cB_dout_o);
    end
    cB_rst_ni = 1'b1;
    @(negedge clkA_i);
    cA_rst_ni = 1'b1;
    repeat (3) @(negedge clkA_i);
  endtask

  task automatic test_single();
    int unsigned n = 0;
    int unsigned base;
    b_mode = 0;
    base = consumed;
    @(negedge clkA_i);
    cA_valid_i = 1'b1;
    cA_din_i   = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clkA_i);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clkB_i);
          n++;
          #5;
          if (cB_valid_o) break;
        end
      end
      begin
        @(negedge clkA_i);
        cA_valid_i = 1'b0;
      end
    join
    checks += 3;
    if (n != S + 1 || cB_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_latency got %0d expected %0d", n, S + 1);
    end
    if (cB_dout_o !== 8'hA5) begin
      errors++; $display("FAIL single_dout got %h expected a5", cB_dout_o);
    end
    if (cA_rdy_o !== 1'b0) begin
      errors++; $display("FAIL single_rdy_busy got %b expected 0", cA_rdy_o);
    end
    wait_rdy("single");
    drain("single");
    repeat (60) @(negedge clkB_i);
    checks++;
    if (consumed - base != 1) begin
      errors++; $display("FAIL single_count got %0d expected 1", consumed - base);
    end
  endtask

  task automatic test_stall();
    int unsigned w = 0;
    b_mode = 1;
    send_word(8'h3C, 0);
    while (!cB_valid_o && w < 100) begin
      @(negedge clkB_i);
      w++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clkB_i);
      checks++;
      if (cB_valid_o !== 1'b1 || cB_dout_o !== 8'h3C || cA_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got v=%b d=%h r=%b expected v=1 d=3c r=0",
                 cB_valid_o, cB_dout_o, cA_rdy_o);
      end
    end
    b_mode = 0;
    drain("stall");
    wait_rdy("stall");
  endtask

  task automatic test_din_churn();
    int unsigned acc = 0;
    b_mode = 0;
    for (int i = 0; i < 3000 && acc < 3; i++) begin
      @(negedge clkA_i);
      cA_valid_i = 1'b1;
      cA_din_i   = 8'($urandom);
      if (cA_rdy_o) begin
        exp_q.push_back(cA_din_i);
        acc++;
      end
    end
    @(negedge clkA_i);
    cA_valid_i = 1'b0;
    checks++;
    if (acc != 3) begin
      errors++; $display("FAIL churn_accepts got %0d expected 3", acc);
    end
    drain("churn");
  endtask

  task automatic test_stream();
    b_mode = 2;
    for (int w = 0; w < 128; w++) send_word(8'(w), $urandom_range(0, 3));
    ha = 135;
    hb = 50;
    for (int w = 128; w < 256; w++) send_word(8'(w), $urandom_range(0, 3));
    drain("stream");
    ha = 50;
    hb = 135;
    b_mode = 0;
    wait_rdy("stream");
  endtask

  task automatic test_src_reset();
    int unsigned w = 0;
    int unsigned base;
    b_mode = 1;
    send_word(8'h77, 0);
    while (!cB_valid_o && w < 100) begin
      @(negedge clkB_i);
      w++;
    end
    base = consumed;
    @(negedge clkA_i);
    cA_rst_ni = 1'b0;
    repeat (3) @(negedge clkA_i);
    checks++;
    if (cA_rdy_o !== 1'b1) begin
      errors++; $display("FAIL rst_rdy got %b expected 1", cA_rdy_o);
    end
    cA_rst_ni = 1'b1;
    b_mode = 0;
    repeat (60) @(negedge clkB_i);
    checks += 3;
    if (consumed - base != 1) begin
      errors++; $display("FAIL rst_count got %0d expected 1", consumed - base);
    end
    if (cB_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b expected 0", cB_valid_o);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rst_pending got %0d expected 0", exp_q.size());
    end
    send_word(8'h5A, 0);
    drain("rst_after");
    wait_rdy("rst_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_din_churn();
    test_stream();
    test_src_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cdc_handshake_4ph

// File: doc/cdc_handshake_4ph.md
# cdc_handshake_4ph

Four-phase req/ack CDC channel that moves one DATA_WIDTH word at a time from the clkA domain to the clkB domain. It is the handshake counterpart to the team's two-deep async FIFO. It is used where throughput is irrelevant but a held, registered word and an explicit completion acknowledgement back to the sender are required, for example configuration writes and status snapshots. Only single-bit req and ack signals cross domains; the data bus is held stable by construction while it is sampled.

## Interface
- DATA_WIDTH, 8, width of transferred word
- clkA_i  input  1  source clock
- cA_rst_ni  input  1  source reset, asynchronous, active-low; clock clkA_i
- cA_valid_i  input  1  source offers cA_din_i
- cA_din_i  input  DATA_WIDTH  source data
- cA_rdy_o  output  1  source may hand over a word (reset 1)
- clkB_i  input  1  destination clock
- cB_rst_ni  input  1  destination reset, asynchronous, active-low; clock clkB_i
- cB_valid_o  output  1  cB_dout_o holds a new word (reset 0)
- cB_dout_o  output  DATA_WIDTH  received word (reset 0)
- cB_rdy_i  input  1  destination consumes the word

## Operation
- Source FSM (clkA) has three states:
  - A_IDLE: cA_rdy_o=1, req=0. On cA_valid_i & cA_rdy_o, latch cA_din_i into cA_data, set req<=1, go to A_REQ.
  - A_REQ: cA_rdy_o=0, req=1. When ack_sync=1, set req<=0 and go to A_DROP.
  - A_DROP: cA_rdy_o=0, req=0. When ack_sync=0, go to A_IDLE.
- Destination FSM (clkB) has three states:
  - B_IDLE: ack=0. When req_sync=1, set cB_dout_o<=cA_data, cB_valid_o<=1, go to B_HOLD.
  - B_HOLD: when cB_valid_o & cB_rdy_i, set cB_valid_o<=0, ack<=1, go to B_ACK.
  - B_ACK: when req_sync=0, set ack<=0 and go to B_IDLE.
- cA_data changes only in A_IDLE. req=1 guarantees cA_data has been stable for at least one clkA cycle before it is sampled in clkB.
- req and ack are registered outputs of their FSMs. Each crosses domains through a cdc_sync_bit.
- cB_dout_o holds its last value after consumption. It updates only on capture.
- cA_valid_i while cA_rdy_o=0 is ignored; the word is not queued.
- cB_rdy_i asserted in B_IDLE or B_ACK has no effect.
- Reset mid-operation:
  - cA reset: forces A_IDLE and req=0. A word already captured in clkB is still delivered exactly once. A word not yet captured is lost.
  - cB reset while the source is in A_REQ: forces B_IDLE and ack=0. The pending req is then re-captured, so a word may be duplicated. The system must overlap both resets; single-sided reset is defined but not lossless.
- Illegal encodings of the 2-bit state registers return the FSM to IDLE.

## Timing
- Let S be the number of synchronizer stages: 2 by default, 3 with the macro.
- Accept (clkA edge k) to cB_valid_o=1: S+1 clkB edges after req is sampled.
- cB consume to cA_rdy_o=1: ack crossing (S clkA edges), then A_DROP, then req fall crossing (S clkB) and ack fall crossing (S clkA), plus one clkA edge for A_DROP to A_IDLE.
- Minimum cycle per word is approximately 2·S·(TclkA+TclkB) plus 4 register cycles. There is no back-to-back acceptance.
- cA_rdy_o falls on the accept edge. There is no combinational path from cA_valid_i to cA_rdy_o.
- There is no combinational path from cB_rdy_i to cB_valid_o.

## Configuration
- CDC_HS_3FF_EN defined: both cdc_sync_bit instances use 3 flops (S=3), and all latencies grow by one cycle per crossing.
- Undefined: S=2.

## Structure
- Package cdc_pkg holds:
  - enums src_state_t {A_IDLE, A_REQ, A_DROP} and dst_state_t {B_IDLE, B_HOLD, B_ACK}
  - localparam CDC_SYNC_STAGES, set from CDC_HS_3FF_EN
- Sub-module cdc_sync_bit:
  - parameter STAGES, inputs clk_i, rst_ni, d_i, output q_o
  - resets to 0
  - instantiated twice: req into clkB, ack into clkA

## Test plan
- Single transfer, clkA=100 MHz, clkB=37 MHz, S=2, cB_rdy_i=1: write 0xA5 → cB_valid_o rises 3 clkB edges after req and cB_dout_o=0xA5. cA_rdy_o returns to 1, and no second cB_valid_o occurs.
- Destination stall: send 0x3C with cB_rdy_i=0 for 20 clkB cycles → cB_valid_o stays 1 and cB_dout_o stays 0x3C. cA_rdy_o stays 0 throughout. Release cB_rdy_i → one consume, then cA_rdy_o=1.
- Stream 256 words 0x00..0xFF with random cA_valid_i and cB_rdy_i, swapping clock ratios (100/37 and 37/100 MHz) → received sequence identical to sent, with no loss or duplicates.
- Source changes cA_din_i every cycle while cA_rdy_o=0 → delivered word equals the value at the accept edge only.
- Assert cA_rst_ni in A_REQ after clkB has captured 0x77 → 0x77 delivered once, and the FSM returns to idle on both sides.
- With CDC_HS_3FF_EN, repeat the first scenario → cB_valid_o rises 4 clkB edges after req.
